// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B one bit per cycle, LSB first,
// with a registered difference, final borrow, busy flag and done pulse.
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               d_bit;
    logic               b_out;

    // One-bit full subtractor on the current operand LSBs
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ bin_q;
        b_out = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = b_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = b_out;
                    done_d   = 1'b1;
                    state_d  = FIN;
                end else begin
                    busy_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Diff   = diff_q;
    assign Borrow = borrow_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): cycle-level reference
// model plus directed literal cases and a randomized sweep.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Diff;
    logic         Borrow;
    logic         Busy;
    logic         Done;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Diff   (Diff),
        .Borrow (Borrow),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;
    int done_cnt = 0;
    int done_at[$];

    // Reference model: cycles remaining in the current operation
    int           m_left = 0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic [W-1:0] p_diff = '0;
    logic         p_borrow = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model update at the active edge using the inputs the DUT samples
    always @(posedge CLK) begin
        logic [W:0] full;
        cyc++;
        if (RST) begin
            m_left   = 0;
            m_diff   = '0;
            m_borrow = 1'b0;
        end else if (m_left == 0) begin
            if (Start) begin
                full     = {1'b0, A} - {1'b0, B};
                p_diff   = full[W-1:0];
                p_borrow = full[W];
                m_left   = W + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_diff   = p_diff;
                m_borrow = p_borrow;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy",   32'(Busy),   32'(m_left >= 2));
            check("done",   32'(Done),   32'(m_left == 1));
            check("diff",   32'(Diff),   32'(m_diff));
            check("borrow", 32'(Borrow), 32'(m_borrow));
        end
        if (Done === 1'b1) begin
            done_cnt++;
            done_at.push_back(cyc);
        end
    end

    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) check({nm, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb);
        bit ok;
        @(negedge CLK);
        A = a; B = b; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(nm, ok);
        if (ok) begin
            check({nm, "_diff"},   32'(Diff),   32'(ed));
            check({nm, "_borrow"}, 32'(Borrow), 32'(eb));
        end
        @(negedge CLK);
    endtask

    initial begin
        bit ok;
        int d0;
        RST = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_diff",   32'(Diff),   32'h0);
        check("rst_borrow", 32'(Borrow), 32'h0);
        check("rst_busy",   32'(Busy),   32'h0);
        check("rst_done",   32'(Done),   32'h0);
        RST = 1'b0;

        run_op("op_5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0);
        run_op("op_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("op_ff_00", 8'hFF, 8'h00, 8'hFF, 1'b0);
        run_op("op_80_80", 8'h80, 8'h80, 8'h00, 1'b0);

        // Operand change and Start during RUN must be ignored
        @(negedge CLK);
        A = 8'h10; B = 8'h20; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        d0 = done_cnt;
        repeat (2) @(negedge CLK);
        A = 8'hFF; B = 8'h00; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done("ign", ok);
        if (ok) begin
            check("ign_diff",   32'(Diff),   32'hF0);
            check("ign_borrow", 32'(Borrow), 32'h1);
        end
        repeat (12) @(negedge CLK);
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of RUN aborts without a Done
        @(negedge CLK);
        A = 8'h5A; B = 8'h3C; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy",   32'(Busy),   32'h0);
        check("abort_done",   32'(Done),   32'h0);
        check("abort_diff",   32'(Diff),   32'h0);
        check("abort_borrow", 32'(Borrow), 32'h0);
        d0 = done_cnt;
        repeat (12) @(negedge CLK);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op("after_abort", 8'h5A, 8'h3C, 8'h1E, 1'b0);

        // Start held high: one result every W+2 cycles
        done_at.delete();
        @(negedge CLK);
        A = 8'h07; B = 8'h03; Start = 1'b1;
        repeat (42) @(negedge CLK);
        Start = 1'b0;
        repeat (12) @(negedge CLK);
        check("held_count", 32'(done_at.size() >= 4), 32'd1);
        for (int i = 1; i < done_at.size(); i++)
            check("held_spacing", 32'(done_at[i] - done_at[i-1]), 32'(W + 2));
        check("held_diff",   32'(Diff),   32'h04);
        check("held_borrow", 32'(Borrow), 32'h0);

        // Randomized sweep with stray Starts, operand churn and rare resets
        d0 = done_cnt;
        for (int i = 0; i < 13000; i++) begin
            @(negedge CLK);
            Start = ($urandom_range(2) == 0);
            A     = W'($urandom);
            B     = W'($urandom);
            RST   = ($urandom_range(699) == 0);
        end
        @(negedge CLK);
        RST = 1'b0; Start = 1'b0;
        repeat (12) @(negedge CLK);
        check("rand_ops", 32'(done_cnt - d0 >= 800), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
